key_conditioner: RTL and testbench
==================================

// Module: key_conditioner
// PURPOSE
//  Conditions the six raw piano-key GPIO lines before they reach control_top,
//  the input_handler channels and the tone mixer. Each key is synchronised,
//  debounced and turned into a clean held level plus one-cycle press/release
//  pulses. Keys are independent; all logic runs in the CLOCK_50 domain.
// PARAMETERS
//  N_KEYS           6       number of key channels
//  DEBOUNCE_CYCLES  250000  stable cycles needed to accept a change (5 ms at 50 MHz); minimum 2
//  CNT_W            18      debounce counter width; 2**CNT_W > DEBOUNCE_CYCLES
//  STUCK_CYCLES     2**25   held cycles before a key is flagged stuck (macro builds only)
//  STUCK_W          26      stuck counter width; 2**STUCK_W > STUCK_CYCLES
// PORTS
//  clock          in   1       system clock (CLOCK_50)
//  resetn         in   1       asynchronous reset, active low
//  raw_keys       in   N_KEYS  unsynchronised GPIO key lines, 1 = pressed
//  enable         in   1       1 = pulses may assert; 0 = pulses masked
//  keys_level     out  N_KEYS  debounced held state, 1 = pressed
//  press_pulse    out  N_KEYS  1-cycle strobe on accepted press
//  release_pulse  out  N_KEYS  1-cycle strobe on accepted release
//  any_pressed    out  1       OR of keys_level
//  stuck          out  N_KEYS  sticky stuck-key flags; tied 0 without the macro
// BEHAVIOUR
//  Reset: all synchronisers, FSMs and counters clear to 0 or IDLE immediately.
//   All outputs are 0 while resetn = 0.
//  Sync: 2-flop synchroniser per key (s1, s2). The FSM samples only s2.
//  Per-key FSM (cnt is the CNT_W debounce counter):
//   IDLE:         s2=1 -> PRESS_WAIT, cnt<=0.
//   PRESS_WAIT:   s2=0 -> IDLE, cnt<=0 (bounce rejected).
//                 s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; level<=1; press_pulse<=enable.
//                 Otherwise cnt++.
//   HELD:         s2=0 -> RELEASE_WAIT, cnt<=0.
//   RELEASE_WAIT: s2=1 -> HELD, cnt<=0.
//                 s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; level<=0; release_pulse<=enable.
//                 Otherwise cnt++.
//  Latency: take edge 0 as the first clock edge to sample raw high. press_pulse and
//   keys_level go high after edge 2+DEBOUNCE_CYCLES. Release latency is identical.
//  Pulses: registered, exactly 1 cycle, never two consecutive cycles for the same key.
//   Several keys may pulse in the same cycle.
//  enable=0: FSMs and keys_level keep tracking. Pulses that would fire are dropped,
//   not deferred.
//  cnt never wraps. It clears on every state change.
//  any_pressed: combinational OR of registered keys_level (no extra latency).
//  Reset mid-operation: state is lost. A key still held after resetn rises is
//   reported as a new press 2+DEBOUNCE_CYCLES edges later.
// CONFIGURATION
//  KEY_COND_STUCK_DETECT_EN defined:
//   - Each key has a STUCK_W counter that increments in HELD/RELEASE_WAIT and
//     saturates at STUCK_CYCLES.
//   - stuck[i]<=1 on the edge the counter reaches STUCK_CYCLES.
//   - The flag and counter clear only on entry to IDLE or on reset.
//   - stuck does not mask press or release pulses.
//  KEY_COND_STUCK_DETECT_EN undefined: no stuck counters exist; stuck is constant 0.
// TESTING (DEBOUNCE_CYCLES=8, CNT_W=4, STUCK_CYCLES=32, STUCK_W=6)
//  1. raw_keys[0] high 30 cycles, then low, enable=1 ->
//     - press_pulse[0] high 1 cycle after edge 10; keys_level[0]=1.
//     - release_pulse[0] 10 edges after the fall; keys_level[0]=0.
//  2. raw_keys[2] repeats a pattern of 5 cycles high then 1 cycle low for 60 cycles ->
//     no pulses; keys_level[2]=0 throughout.
//  3. raw_keys[1] and raw_keys[4] rise on the same cycle ->
//     press_pulse=6'b010010 for exactly 1 cycle; any_pressed=1.
//  4. enable=0 while key 3 is pressed and released ->
//     keys_level[3] rises and falls with normal latency; press_pulse and release_pulse stay 0.
//  5. resetn pulsed low while key 5 is in HELD, key kept high ->
//     - all outputs 0 asynchronously during reset.
//     - press_pulse[5] 10 edges after resetn rises.
//  6. Macro on: key 0 held 60 cycles -> stuck[0]=1 once 32 held cycles have counted;
//     it clears after the debounced release. Macro off: stuck stays 6'b0.

Source files
------------

// File: rtl/key_conditioner.sv
// Piano-key conditioner: per-key 2-flop synchroniser, debounce FSM, held level and press/release strobes.
// Optional stuck-key detection is compiled in with `define KEY_COND_STUCK_DETECT_EN.
module key_conditioner #(
    parameter int N_KEYS          = 6,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int STUCK_CYCLES    = 2**25,
    parameter int STUCK_W         = 26
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] raw_keys,
    input  logic              enable,
    output logic [N_KEYS-1:0] keys_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic              any_pressed,
    output logic [N_KEYS-1:0] stuck
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] sync_p0;
    logic [N_KEYS-1:0] sync_p1;
    logic [1:0]        state [N_KEYS];
    logic [CNT_W-1:0]  cnt   [N_KEYS];

    // Stage p0/p1: metastability synchroniser; the FSM only ever looks at sync_p1.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_p0       <= '0;
            sync_p1       <= '0;
            keys_level    <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                state[k] <= IDLE;
                cnt[k]   <= '0;
            end
        end else begin
            sync_p0       <= raw_keys;
            sync_p1       <= sync_p0;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                case (state[k])
                    IDLE: begin
                        if (sync_p1[k]) begin
                            state[k] <= PRESS_WAIT;
                            cnt[k]   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync_p1[k]) begin
                            state[k] <= IDLE;
                            cnt[k]   <= '0;
                        end else if (cnt[k] == CNT_LAST) begin
                            state[k]       <= HELD;
                            cnt[k]         <= '0;
                            keys_level[k]  <= 1'b1;
                            press_pulse[k] <= enable;
                        end else begin
                            cnt[k] <= cnt[k] + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!sync_p1[k]) begin
                            state[k] <= RELEASE_WAIT;
                            cnt[k]   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync_p1[k]) begin
                            state[k] <= HELD;
                            cnt[k]   <= '0;
                        end else if (cnt[k] == CNT_LAST) begin
                            state[k]         <= IDLE;
                            cnt[k]           <= '0;
                            keys_level[k]    <= 1'b0;
                            release_pulse[k] <= enable;
                        end else begin
                            cnt[k] <= cnt[k] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[k] <= IDLE;
                        cnt[k]   <= '0;
                    end
                endcase
            end
        end
    end

    assign any_pressed = |keys_level;

`ifdef KEY_COND_STUCK_DETECT_EN
    localparam logic [STUCK_W-1:0] STUCK_MAX  = STUCK_W'(STUCK_CYCLES);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

    logic [STUCK_W-1:0] stuck_cnt [N_KEYS];
    logic [N_KEYS-1:0]  release_accept;

    always_comb begin
        release_accept = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            release_accept[k] = (state[k] == RELEASE_WAIT) && !sync_p1[k] && (cnt[k] == CNT_LAST);
        end
    end

    // keys_level is high exactly in HELD/RELEASE_WAIT, so it gates the held-time count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stuck <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                stuck_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (release_accept[k]) begin
                    stuck_cnt[k] <= '0;
                    stuck[k]     <= 1'b0;
                end else if (keys_level[k] && (stuck_cnt[k] != STUCK_MAX)) begin
                    stuck_cnt[k] <= stuck_cnt[k] + STUCK_W'(1);
                    if (stuck_cnt[k] == STUCK_LAST) begin
                        stuck[k] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign stuck = '0;

    // Stuck sizing parameters stay part of the interface so both builds share one instantiation.
    if (STUCK_CYCLES < 1 || STUCK_W < 1) begin : g_stuck_cfg_unused
    end
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner using a run-length reference model of the debounce rules.
`timescale 1ns/1ps
module tb_key_conditioner;

    localparam int N  = 6;
    localparam int D  = 8;
    localparam int SC = 32;

    logic         clock = 1'b0;
    logic         resetn;
    logic [N-1:0] raw_keys;
    logic         enable;
    logic [N-1:0] keys_level, press_pulse, release_pulse, stuck;
    logic         any_pressed;

    int chk_n  = 0;
    int fail_n = 0;

    key_conditioner #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(4), .STUCK_CYCLES(SC), .STUCK_W(6)
    ) dut (
        .clock(clock), .resetn(resetn), .raw_keys(raw_keys), .enable(enable),
        .keys_level(keys_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .any_pressed(any_pressed), .stuck(stuck)
    );

    always #5 clock = ~clock;

    // Reference model: the FSM sees raw delayed by two edges; a level flips once that delayed
    // input has disagreed with it for D+1 consecutive edges. Held time counts edges at level 1.
    logic [N-1:0] m_d1, m_d2, m_level, m_press, m_rel, m_stuck;
    logic [N-1:0] n_level, n_press, n_rel, n_stuck;
    int m_run [N];
    int m_held[N];
    int n_run [N];
    int n_held[N];

    always_comb begin
        n_level = m_level;
        n_press = '0;
        n_rel   = '0;
        n_stuck = m_stuck;
        for (int k = 0; k < N; k++) begin
            n_run[k]  = (m_d2[k] != m_level[k]) ? m_run[k] + 1 : 0;
            n_held[k] = m_held[k];
            if (n_run[k] == D + 1) begin
                n_level[k] = ~m_level[k];
                n_run[k]   = 0;
                n_press[k] = enable & ~m_level[k];
                n_rel[k]   = enable & m_level[k];
            end
            if (m_level[k]) begin
                if (!n_level[k]) begin
                    n_held[k]  = 0;
                    n_stuck[k] = 1'b0;
                end else begin
                    n_held[k] = (m_held[k] < SC) ? m_held[k] + 1 : SC;
                    if (n_held[k] == SC) n_stuck[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_d1 <= '0; m_d2 <= '0; m_level <= '0; m_press <= '0; m_rel <= '0; m_stuck <= '0;
            for (int k = 0; k < N; k++) begin
                m_run[k]  <= 0;
                m_held[k] <= 0;
            end
        end else begin
            m_d1 <= raw_keys; m_d2 <= m_d1;
            m_level <= n_level; m_press <= n_press; m_rel <= n_rel; m_stuck <= n_stuck;
            for (int k = 0; k < N; k++) begin
                m_run[k]  <= n_run[k];
                m_held[k] <= n_held[k];
            end
        end
    end

    logic [N-1:0] exp_stuck;
`ifdef KEY_COND_STUCK_DETECT_EN
    assign exp_stuck = m_stuck;
`else
    assign exp_stuck = '0;
`endif

    logic [4*N:0] act_out, exp_out;
    assign act_out = {keys_level, press_pulse, release_pulse, any_pressed, stuck};
    assign exp_out = {m_level, m_press, m_rel, |m_level, exp_stuck};

    task automatic test_reset();
        resetn = 1'b0; raw_keys = '0; enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk_n++;
            if (act_out !== {(4*N+1){1'b0}}) begin
                fail_n++;
                $display("FAIL reset cycle %0d: outputs %b, required all zero", c, act_out);
            end
        end
        resetn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out) begin
                fail_n++;
                $display("FAIL reset_idle cycle %0d: outputs %b, expected %b", c, act_out, exp_out);
            end
        end
    endtask

    task automatic test_single_press();
        raw_keys[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out) begin
                fail_n++;
                $display("FAIL single_press cycle %0d: outputs %b, expected %b", c, act_out, exp_out);
            end
            chk_n++;
            if (press_pulse[0] !== (c == 10) || release_pulse[0] !== (c == 40)) begin
                fail_n++;
                $display("FAIL single_press_timing cycle %0d: press %b release %b, required press at 10 release at 40",
                         c, press_pulse[0], release_pulse[0]);
            end
            if (c == 29) raw_keys[0] = 1'b0;
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 80; c++) begin
            raw_keys[2] = (c < 60) && ((c % 6) != 5);
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out || keys_level[2] !== 1'b0 || press_pulse[2] !== 1'b0 || release_pulse[2] !== 1'b0) begin
                fail_n++;
                $display("FAIL bounce cycle %0d: outputs %b, expected %b with key2 quiet", c, act_out, exp_out);
            end
        end
    endtask

    task automatic test_simultaneous();
        int hits = 0;
        raw_keys[1] = 1'b1; raw_keys[4] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out) begin
                fail_n++;
                $display("FAIL simultaneous cycle %0d: outputs %b, expected %b", c, act_out, exp_out);
            end
            if (press_pulse == 6'b010010) hits++;
        end
        chk_n++;
        if (hits != 1 || any_pressed !== 1'b1) begin
            fail_n++;
            $display("FAIL simultaneous_pulse: pulse cycles %0d any_pressed %b, required 1 and 1", hits, any_pressed);
        end
        raw_keys[1] = 1'b0; raw_keys[4] = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out) begin
                fail_n++;
                $display("FAIL simultaneous_release cycle %0d: outputs %b, expected %b", c, act_out, exp_out);
            end
        end
    endtask

    task automatic test_enable_off();
        enable = 1'b0; raw_keys[3] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out || press_pulse[3] !== 1'b0 || release_pulse[3] !== 1'b0
                || keys_level[3] !== (c >= 10 && c < 40)) begin
                fail_n++;
                $display("FAIL enable_off cycle %0d: outputs %b, expected %b", c, act_out, exp_out);
            end
            if (c == 29) raw_keys[3] = 1'b0;
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        raw_keys[5] = 1'b1;
        repeat (15) @(negedge clock);
        chk_n++;
        if (keys_level[5] !== 1'b1) begin
            fail_n++;
            $display("FAIL reset_mid_held: keys_level[5] %b, required 1", keys_level[5]);
        end
        resetn = 1'b0;
        #1;
        chk_n++;
        if (act_out !== {(4*N+1){1'b0}}) begin
            fail_n++;
            $display("FAIL reset_mid_async: outputs %b, required all zero", act_out);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out || press_pulse[5] !== (c == 10)) begin
                fail_n++;
                $display("FAIL reset_mid cycle %0d: outputs %b, expected %b, press[5] due at 10", c, act_out, exp_out);
            end
        end
        raw_keys[5] = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_stuck();
        raw_keys[0] = 1'b1;
        for (int c = 0; c < 90; c++) begin
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out) begin
                fail_n++;
                $display("FAIL stuck cycle %0d: outputs %b, expected %b", c, act_out, exp_out);
            end
            if (c == 59) begin
`ifdef KEY_COND_STUCK_DETECT_EN
                chk_n++;
                if (stuck[0] !== 1'b1) begin
                    fail_n++;
                    $display("FAIL stuck_set: stuck[0] %b, required 1", stuck[0]);
                end
`else
                chk_n++;
                if (stuck !== 6'b0) begin
                    fail_n++;
                    $display("FAIL stuck_off: stuck %b, required 000000", stuck);
                end
`endif
                raw_keys[0] = 1'b0;
            end
        end
        chk_n++;
        if (stuck[0] !== 1'b0 || keys_level[0] !== 1'b0) begin
            fail_n++;
            $display("FAIL stuck_clear: stuck[0] %b level %b, required 0 0", stuck[0], keys_level[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 11) == 0) raw_keys[k] = ~raw_keys[k];
            end
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out) begin
                fail_n++;
                $display("FAIL random cycle %0d: outputs %b, expected %b", c, act_out, exp_out);
            end
        end
        raw_keys = '0; enable = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            chk_n++;
            if (act_out !== exp_out) begin
                fail_n++;
                $display("FAIL random_drain cycle %0d: outputs %b, expected %b", c, act_out, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_enable_off();
        test_reset_mid();
        test_stuck();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", chk_n, fail_n);
        $finish;
    end

endmodule
